// File: rtl/adder_pipe_pkg.sv
// Shared types and sizes for the 8-bit adder pipeline.
package adder_pipe_pkg;

    localparam int SUM_W         = 8;
    localparam int RESULT_W      = SUM_W + 1;
    localparam int DEFAULT_DEPTH = 4;

    typedef struct packed {
        logic             carry;
        logic [SUM_W-1:0] sum;
    } result_t;

endpackage

// File: rtl/adder_result_collector_if.sv
// Adder-result input and consumer pop handshake of the result collector.
interface adder_result_collector_if;
    import adder_pipe_pkg::*;

    logic [SUM_W-1:0]    Sum_result;
    logic                Sum_carry;
    logic                Data_ready;
    logic                Out_read;
    logic [RESULT_W-1:0] Out_data;
    logic                Out_valid;

    modport master (
        output Sum_result, Sum_carry, Data_ready, Out_read,
        input  Out_data, Out_valid
    );

    modport slave (
        input  Sum_result, Sum_carry, Data_ready, Out_read,
        output Out_data, Out_valid
    );
endinterface

// File: rtl/result_fifo.sv
// Generic synchronous FIFO; rd_dat is a combinational head read masked to 0 when empty.
// Latency: a push is visible after the accepting edge; a pop shows the next head after its edge.
// Backpressure: a push into a full FIFO is refused unless a pop is accepted the same cycle.
module result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level,
    output logic             push_acc,
    output logic             pop_acc
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign empty    = (level == '0);
    assign full     = (level == LVL_W'(DEPTH));
    assign pop_acc  = rd_rdy && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_acc = wr_vld && (!full || pop_acc);
    assign rd_dat   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_acc && !pop_acc) begin
                level <= level + 1'b1;
            end else if (pop_acc && !push_acc) begin
                level <= level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_result_collector.sv
// Buffers qualified adder results, counts them, flags drops; optional accumulator via COLLECTOR_ACCUM_EN.
// Latency: 1 cycle from Data_ready to Out_valid/Fifo_level/Result_count/Accum_total.
// Backpressure: none toward the adder; a result arriving at a full FIFO without a pop is dropped.
module adder_result_collector
    import adder_pipe_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int ACC_W = 16,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    adder_result_collector_if.slave  bus,
    input  logic                     Clear,
    output logic [LVL_W-1:0]         Fifo_level,
    output logic                     Overflow,
    output logic [7:0]               Result_count,
    output logic [ACC_W-1:0]         Accum_total,
    output logic                     Accum_wrap
);

    result_t in_res;
    logic    fifo_full;
    logic    fifo_empty;
    logic    push_acc;
    logic    pop_acc;
    logic    drop;

    assign in_res = '{carry: bus.Sum_carry, sum: bus.Sum_result};

    result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (RESULT_W)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_vld   (bus.Data_ready),
        .wr_dat   (in_res),
        .rd_rdy   (bus.Out_read),
        .rd_dat   (bus.Out_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (Fifo_level),
        .push_acc (push_acc),
        .pop_acc  (pop_acc)
    );

    assign bus.Out_valid = !fifo_empty;
    assign drop          = bus.Data_ready && fifo_full && !pop_acc;

    // Clear wins over counting; a coincident push still lands in the FIFO.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            Result_count <= '0;
            Overflow     <= 1'b0;
        end else if (Clear) begin
            Result_count <= '0;
            Overflow     <= 1'b0;
        end else begin
            if (push_acc) begin
                Result_count <= Result_count + 8'd1;
            end
            if (drop) begin
                Overflow <= 1'b1;
            end
        end
    end

`ifdef COLLECTOR_ACCUM_EN
    logic [ACC_W:0] acc_sum;

    assign acc_sum = {1'b0, Accum_total} + (ACC_W+1)'(in_res);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            Accum_total <= '0;
            Accum_wrap  <= 1'b0;
        end else if (Clear) begin
            Accum_total <= '0;
            Accum_wrap  <= 1'b0;
        end else if (push_acc) begin
            Accum_total <= acc_sum[ACC_W-1:0];
            Accum_wrap  <= Accum_wrap | acc_sum[ACC_W];
        end
    end
`else
    assign Accum_total = '0;
    assign Accum_wrap  = 1'b0;
`endif

endmodule

// File: tb/tb_adder_result_collector.sv
// Directed bench for adder_result_collector at DEPTH=4, ACC_W=16; follows COLLECTOR_ACCUM_EN.
module tb_adder_result_collector;

`ifdef COLLECTOR_ACCUM_EN
    localparam bit ACC_ON = 1'b1;
`else
    localparam bit ACC_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       Clear;
    logic [2:0] Fifo_level;
    logic       Overflow;
    logic [7:0] Result_count;
    logic [15:0] Accum_total;
    logic       Accum_wrap;

    int checks = 0;
    int passed = 0;

    adder_result_collector_if bus ();

    adder_result_collector #(
        .DEPTH (4),
        .ACC_W (16)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus.slave),
        .Clear        (Clear),
        .Fifo_level   (Fifo_level),
        .Overflow     (Overflow),
        .Result_count (Result_count),
        .Accum_total  (Accum_total),
        .Accum_wrap   (Accum_wrap)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic dr, input logic carry, input logic [7:0] sum, input logic rd);
        bus.Data_ready = dr;
        bus.Sum_carry  = carry;
        bus.Sum_result = sum;
        bus.Out_read   = rd;
    endtask

    initial begin
        reset_n = 1'b0;
        Clear   = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        check("rst_valid", bus.Out_valid, 0);
        check("rst_data", bus.Out_data, 0);
        check("rst_level", Fifo_level, 0);
        check("rst_ovf", Overflow, 0);
        check("rst_count", Result_count, 0);
        check("rst_accum", Accum_total, 0);
        check("rst_wrap", Accum_wrap, 0);

        // single result
        reset_n = 1'b1;
        drive(1'b1, 1'b0, 8'd8, 1'b0);
        tick();
        check("one_valid", bus.Out_valid, 1);
        check("one_data", bus.Out_data, 9'h008);
        check("one_level", Fifo_level, 1);
        check("one_count", Result_count, 1);
        check("one_accum", Accum_total, ACC_ON ? 8 : 0);

        // ordering
        drive(1'b1, 1'b0, 8'hFF, 1'b0);
        tick();
        drive(1'b1, 1'b1, 8'h00, 1'b0);
        tick();
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        check("ord_level3", Fifo_level, 3);
        check("ord_accum", Accum_total, ACC_ON ? 519 : 0);
        check("ord_pop0", bus.Out_data, 9'h008);
        tick();
        check("ord_pop1", bus.Out_data, 9'h0FF);
        tick();
        check("ord_pop2", bus.Out_data, 9'h100);
        tick();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        check("ord_level0", Fifo_level, 0);
        check("ord_empty_data", bus.Out_data, 0);
        check("ord_empty_valid", bus.Out_valid, 0);
        check("ord_count", Result_count, 3);

        // overflow: five pushes into four slots
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 8'h11 + 8'(i), 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        check("ovf_level", Fifo_level, 4);
        check("ovf_flag", Overflow, 1);
        check("ovf_count", Result_count, 7);
        check("ovf_head", bus.Out_data, 9'h011);
        check("ovf_accum", Accum_total, ACC_ON ? 593 : 0);

        // clear alone leaves the FIFO intact
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        check("clr_ovf", Overflow, 0);
        check("clr_count", Result_count, 0);
        check("clr_accum", Accum_total, 0);
        check("clr_level", Fifo_level, 4);

        // full with push+pop
        drive(1'b1, 1'b0, 8'h33, 1'b1);
        tick();
        check("fpp_level", Fifo_level, 4);
        check("fpp_ovf", Overflow, 0);
        check("fpp_head", bus.Out_data, 9'h012);
        check("fpp_count", Result_count, 1);
        check("fpp_accum", Accum_total, ACC_ON ? 8'h33 : 0);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        tick();
        tick();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        check("fpp_tail", bus.Out_data, 9'h033);
        check("fpp_level1", Fifo_level, 1);

        // clear with coincident push
        Clear = 1'b1;
        drive(1'b1, 1'b0, 8'h03, 1'b0);
        tick();
        Clear = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        check("clrp_count", Result_count, 0);
        check("clrp_accum", Accum_total, 0);
        check("clrp_ovf", Overflow, 0);
        check("clrp_level", Fifo_level, 2);

        // 300 results of 9'h1FF, drained every cycle
        drive(1'b1, 1'b1, 8'hFF, 1'b1);
        for (int i = 0; i < 300; i++) begin
            tick();
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        check("wrap_count", Result_count, 44);
        check("wrap_flag", Accum_wrap, ACC_ON ? 1 : 0);
        check("wrap_accum", Accum_total, ACC_ON ? 22228 : 0);
        check("wrap_level", Fifo_level, 2);
        check("wrap_head", bus.Out_data, 9'h1FF);
        check("wrap_ovf", Overflow, 0);

        // reset mid-operation with a pop pending
        drive(1'b1, 1'b0, 8'h44, 1'b0);
        tick();
        check("mid_level3", Fifo_level, 3);
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        check("mid_valid", bus.Out_valid, 0);
        check("mid_data", bus.Out_data, 0);
        check("mid_level", Fifo_level, 0);
        check("mid_count", Result_count, 0);
        check("mid_accum", Accum_total, 0);
        check("mid_wrap", Accum_wrap, 0);
        reset_n = 1'b1;
        tick();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        check("empty_pop_level", Fifo_level, 0);
        check("empty_pop_valid", bus.Out_valid, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
